// File: rtl/jtag_tx_arbiter_pkg.sv
// Shared types and constants for the JTAG UART transmit arbiter.
// Register map and write-space field layout of the JTAG UART slave.
package jtag_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POLL,
    GAP,
    ARB,
    WRITE
  } state_t;

  localparam logic REG_DATA    = 1'b0;
  localparam logic REG_CONTROL = 1'b1;

  localparam int WSPACE_LSB = 16;
  localparam int WSPACE_MSB = 31;

  localparam logic [6:0] CREDIT_MAX = 7'd64;

  // The slave can report more space than the FIFO we track
  function automatic logic [6:0] clamp_wspace(
    input logic [15:0] ws
  );
    if (ws > 16'(CREDIT_MAX)) begin
      return CREDIT_MAX;
    end
    return ws[6:0];
  endfunction

endpackage

// File: rtl/jtag_tx_arbiter_rr_arb2.sv
// Two-way round-robin grant with a registered last-grant pointer.
// last=1 means req1 won most recently, so req0 wins the next tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       last
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b11:   grant = last ? 2'b01 : 2'b10;
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= 1'b1;
    end else if (advance && (|grant)) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/jtag_tx_arbiter.sv
// Arbitrates two byte streams onto a JTAG UART Avalon slave,
// polling the control register for write space before writing.
module jtag_tx_arbiter
  import jtag_tx_arbiter_pkg::*;
#(
  parameter int POLL_GAP = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  output logic        avm_address,
  output logic        avm_chipselect,
  output logic        avm_read_n,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic [6:0]  credits,
  output logic        busy
);

  localparam logic [7:0] GAP_LOAD = 8'(POLL_GAP - 1);

  state_t     state;
  state_t     state_nx;
  logic [7:0] gap_cnt;
  logic [6:0] credits_q;
  logic [7:0] wr_byte;
  logic [1:0] grant;
  logic       last_grant;
  logic       any_valid;
  logic       poll_done;
  logic       wr_done;
  logic [6:0] ws;
  logic       unused;

  assign any_valid = req0_valid | req1_valid;
  assign poll_done = (state == POLL) && !avm_waitrequest;
  assign wr_done   = (state == WRITE) && !avm_waitrequest;
  assign ws        = clamp_wspace(avm_readdata[WSPACE_MSB:WSPACE_LSB]);
  assign unused    = ^avm_readdata[WSPACE_LSB-1:0] ^ last_grant;

  rr_arb2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     ({req1_valid, req0_valid}),
    .advance (state == ARB),
    .grant   (grant),
    .last    (last_grant)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (any_valid) begin
          state_nx = (credits_q == '0) ? POLL : ARB;
        end
      end
      POLL: begin
        if (!avm_waitrequest) begin
          state_nx = (ws != '0) ? ARB : GAP;
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_nx = any_valid ? POLL : IDLE;
        end
      end
      ARB: begin
        state_nx = any_valid ? WRITE : IDLE;
      end
      WRITE: begin
        if (!avm_waitrequest) begin
          // credits_q > 1 means space remains after this write
          state_nx = (credits_q > 7'd1 && any_valid) ? ARB : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_cnt   <= '0;
      credits_q <= '0;
      wr_byte   <= '0;
    end else begin
      if (poll_done) begin
        credits_q <= ws;
        gap_cnt   <= GAP_LOAD;
      end
      if (state == GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 8'd1;
      end
      if (wr_done && credits_q != '0) begin
        credits_q <= credits_q - 7'd1;
      end
      if (state == ARB && (|grant)) begin
        wr_byte <= grant[1] ? req1_data : req0_data;
      end
    end
  end

  always_comb begin
    avm_chipselect = 1'b0;
    avm_read_n     = 1'b1;
    avm_write_n    = 1'b1;
    avm_address    = REG_DATA;
    req0_ready     = 1'b0;
    req1_ready     = 1'b0;
    unique case (state)
      POLL: begin
        avm_chipselect = 1'b1;
        avm_read_n     = 1'b0;
        avm_address    = REG_CONTROL;
      end
      WRITE: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_DATA;
      end
      ARB: begin
        req0_ready = grant[0];
        req1_ready = grant[1];
      end
      default: ;
    endcase
  end

  assign avm_writedata = {24'h0, wr_byte};
  assign credits       = credits_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_jtag_tx_arbiter.sv
// Bench for jtag_tx_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of requesters, credits and slave.
module tb_jtag_tx_arbiter;

  localparam int GAP = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0;
  logic [7:0]  req0_data = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [7:0]  req1_data = '0;
  logic        req1_ready;
  logic        avm_address;
  logic        avm_chipselect;
  logic        avm_read_n;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = '0;
  logic        avm_waitrequest = 1'b0;
  logic [6:0]  credits;
  logic        busy;

  always #5 clk = ~clk;

  jtag_tx_arbiter #(.POLL_GAP(GAP)) dut (
    .clk             (clk),
    .reset           (reset),
    .req0_valid      (req0_valid),
    .req0_data       (req0_data),
    .req0_ready      (req0_ready),
    .req1_valid      (req1_valid),
    .req1_data       (req1_data),
    .req1_ready      (req1_ready),
    .avm_address     (avm_address),
    .avm_chipselect  (avm_chipselect),
    .avm_read_n      (avm_read_n),
    .avm_write_n     (avm_write_n),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .credits         (credits),
    .busy            (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] exp_wr[$];
  logic [7:0] written[$];
  int         ws_q[$];
  int         grants[$];
  int         ws_dflt = 64;
  bit         en_rand = 0;
  int         wr_wait = 0;
  int         rd_wait = 0;
  bit         strict_gap = 1;

  int          cm, readies, writes, polls, wait_left, gap_t, cyc;
  int          max_cr, first_op, wr_wait_cyc;
  bit          last, acc_on, wr_hold, gap_pend, v0, v1;
  logic [31:0] held;

  task automatic model_reset();
    cm = 0; last = 1; readies = 0; writes = 0; polls = 0;
    acc_on = 0; wait_left = 0; wr_hold = 0; gap_pend = 0;
    max_cr = 0; first_op = 0; wr_wait_cyc = 0;
    exp_wr.delete(); grants.delete(); written.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cs"}, avm_chipselect, 0);
    check({tag, "_rdn"}, avm_read_n, 1);
    check({tag, "_wrn"}, avm_write_n, 1);
    check({tag, "_addr"}, avm_address, 0);
    check({tag, "_wdata"}, avm_writedata, 0);
    check({tag, "_rdy"}, {req1_ready, req0_ready}, 0);
    check({tag, "_cred"}, credits, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic sample();
    bit g, eg;
    int wsm;
    check("credits", credits, cm);
    if (int'(credits) > max_cr) max_cr = int'(credits);
    check("rw_excl", !avm_read_n && !avm_write_n, 0);
    if (req0_ready || req1_ready) begin
      g = req1_ready;
      check("rdy_onehot", req0_ready && req1_ready, 0);
      check("rdy_valid", g ? v1 : v0, 1);
      eg = (v0 && v1) ? !last : v1;
      check("rr_grant", g, eg);
      check("arb_cs", avm_chipselect, 0);
      last = g;
      grants.push_back(int'(g));
      if (g && q1.size() != 0) exp_wr.push_back(q1.pop_front());
      else if (!g && q0.size() != 0) exp_wr.push_back(q0.pop_front());
      readies++;
    end
    if (avm_chipselect) begin
      if (first_op == 0) first_op = avm_write_n ? 1 : 2;
      check("cs_op", avm_read_n && avm_write_n, 0);
      if (!avm_write_n) begin
        check("wr_addr", avm_address, 0);
        check("wr_credit", cm > 0, 1);
        if (exp_wr.size() != 0)
          check("wr_data", avm_writedata, {24'h0, exp_wr[0]});
        else
          check("wr_orphan", 1, 0);
        if (wr_hold) check("wr_stable", avm_writedata, held);
        if (!avm_waitrequest) begin
          written.push_back(avm_writedata[7:0]);
          if (exp_wr.size() != 0) void'(exp_wr.pop_front());
          if (cm > 0) cm--;
          writes++;
          wr_hold = 0;
          acc_on = 0;
        end else begin
          wr_hold = 1;
          held = avm_writedata;
          wr_wait_cyc++;
        end
      end else if (!avm_read_n) begin
        check("rd_addr", avm_address, 1);
        if (gap_pend) begin
          gap_pend = 0;
          if (strict_gap) check("gap_len", cyc - gap_t, GAP + 1);
          else check("gap_min", (cyc - gap_t) >= GAP + 1, 1);
        end
        if (!avm_waitrequest) begin
          wsm = (ws_q.size() != 0) ? ws_q.pop_front() : ws_dflt;
          cm = (wsm > 64) ? 64 : wsm;
          polls++;
          if (cm == 0) begin
            gap_pend = 1;
            gap_t = cyc;
          end
          acc_on = 0;
        end
      end
    end
    check("rdy_per_wr", (readies - writes) >= 0 && (readies - writes) <= 1, 1);
  endtask

  task automatic step();
    int ws;
    @(negedge clk);
    v0 = q0.size() != 0 && (!en_rand || $urandom_range(0, 3) != 0);
    v1 = q1.size() != 0 && (!en_rand || $urandom_range(0, 3) != 0);
    req0_valid = v0;
    req1_valid = v1;
    req0_data = v0 ? q0[0] : 8'($urandom);
    req1_data = v1 ? q1[0] : 8'($urandom);
    ws = (ws_q.size() != 0) ? ws_q[0] : ws_dflt;
    avm_readdata = {16'(ws), 16'($urandom)};
    if (avm_chipselect && !acc_on) begin
      acc_on = 1;
      if (!avm_write_n)
        wait_left = (wr_wait < 0) ? $urandom_range(0, 3) : wr_wait;
      else
        wait_left = (rd_wait < 0) ? $urandom_range(0, 3) : rd_wait;
    end
    avm_waitrequest = acc_on ? (wait_left > 0) : 1'($urandom_range(0, 1));
    if (acc_on && wait_left > 0) wait_left--;
    #1;
    sample();
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    req0_valid = 0;
    req1_valid = 0;
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    model_reset();
    q0.delete(); q1.delete(); ws_q.delete();
    reset = 0;
  endtask

  task automatic run(input int budget);
    int n;
    n = 0;
    step();
    n++;
    while ((q0.size() != 0 || q1.size() != 0 || exp_wr.size() != 0 || busy)
           && n < budget) begin
      step();
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0 || exp_wr.size() != 0 || busy)
      check("timeout", 0, 1);
  endtask

  int rnd_vals[7];
  int nbytes;

  initial begin
    cyc = 0;
    model_reset();

    // S1: single byte, one poll returning 64
    do_reset();
    q0.push_back(8'h41);
    ws_q.push_back(16'h0040);
    run(500);
    check("s1_polls", polls, 1);
    check("s1_writes", writes, 1);
    check("s1_data", written.size() != 0 ? written[0] : 8'hxx, 8'h41);
    check("s1_cred", credits, 63);

    // S2: both requesters saturated
    do_reset();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(8'($urandom));
      q1.push_back(8'($urandom));
    end
    ws_q.push_back(64);
    run(500);
    check("s2_ngrant", grants.size(), 6);
    for (int i = 0; i < 6; i++)
      check("s2_grant", i < grants.size() ? grants[i] : -1, i % 2);
    check("s2_writes", writes, 6);

    // S3: two empty polls then space for two
    do_reset();
    ws_q = '{0, 0, 2};
    for (int i = 0; i < 3; i++) q0.push_back(8'(8'h10 + i));
    run(1000);
    check("s3_polls", polls, 4);
    check("s3_writes", writes, 3);

    // S4: slave stalls a write for 5 cycles
    do_reset();
    wr_wait = 5;
    q0.push_back(8'h33);
    ws_q.push_back(64);
    run(500);
    check("s4_stall", wr_wait_cyc, 5);
    check("s4_writes", writes, 1);
    check("s4_cred", credits, 63);

    // S5: reset during a stalled write
    do_reset();
    q0.push_back(8'h77);
    ws_q.push_back(64);
    for (int n = 0; n < 200 && !wr_hold; n++) step();
    check("s5_in_write", wr_hold, 1);
    reset = 1;
    #1;
    check_reset_vals("s5");
    @(negedge clk);
    model_reset();
    q0.delete();
    wr_wait = 0;
    reset = 0;
    q0.push_back(8'h5A);
    run(500);
    check("s5_first_poll", first_op, 1);
    check("s5_data", written.size() != 0 ? written[0] : 8'hxx, 8'h5A);

    // S6: oversize write space saturates
    do_reset();
    ws_q.push_back(16'h0100);
    q1.push_back(8'h66);
    run(500);
    check("s6_sat", max_cr, 64);
    check("s6_cred", credits, 63);

    // Randomized traffic, stalls and write-space responses
    do_reset();
    en_rand = 1;
    wr_wait = -1;
    rd_wait = -1;
    strict_gap = 0;
    rnd_vals = '{0, 1, 2, 3, 64, 16'h0100, 5};
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 5) == 6) ws_q.push_back(0);
      else if ($urandom_range(0, 7) == 0)
        ws_q.push_back($urandom_range(0, 16'hffff));
      else ws_q.push_back(rnd_vals[$urandom_range(0, 6)]);
    end
    nbytes = 0;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 1) == 1) q1.push_back(8'($urandom));
      else q0.push_back(8'($urandom));
      nbytes++;
    end
    run(30000);
    check("rand_writes", writes, nbytes);
    check("rand_readies", readies, nbytes);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
